float_sub_12bit_seq: RTL
========================

# float_sub_12bit_seq

Multi-cycle 12-bit floating-point subtractor, the inverse operation to the team's combinational 12-bit float adder. It uses the same operand format: bit 11 sign, bits 10:7 exponent e (unbiased), bits 6:0 fraction f, value = 1.f × 2^e. It computes |x| − |y| with a start/done handshake. Alignment and post-subtraction normalization are iterative, one bit per cycle, which keeps the datapath small for the sequential ALU built on the existing float blocks.

## Interface
- No parameters (format fixed: 1 sign, 4 exponent, 7 fraction, hidden 1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x  in  12  minuend; sign bit ignored (treated as magnitude).
- y  in  12  subtrahend; sign bit ignored.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse; z/underflow valid from this cycle.
- z  out  12  result {sign, e, f}; holds until next completion.
- underflow  out  1  result flushed to zero by exponent underflow; held with z.

## Operation
- States: IDLE, ALIGN, SUB, NORM, DONE.
- IDLE and start=1 at an edge: register operands as 8-bit mantissas {1,f} with exponents.
  - If {ye,yf} > {xe,xf}: swap the operands, sign=1. Otherwise sign=0.
  - d = xe − ye (d ≥ 0 after swap).
  - Next state: ALIGN if d ≠ 0, else SUB.
- ALIGN:
  - If d ≥ 8: ym=0 in one cycle, go to SUB.
  - Else: each cycle ym >>= 1 (zero fill) and d −= 1. Go to SUB when d reaches 0.
  - A = alignment cycles: 0 (d=0), d (1..7), 1 (d≥8).
- SUB: m = xm − ym (8 bit, never borrows; truncation, no rounding).
  - If m = 0: go to DONE with z=0x000 and underflow=0. Sign is forced to 0.
  - Otherwise go to NORM.
- NORM, one check per cycle:
  - If m[7]=1: go to DONE with z={sign, e, m[6:0]}, underflow=0.
  - Else if e=0: go to DONE with z=0x000, underflow=1.
  - Else: m <<= 1, e −= 1.
  - N = number of shifts performed.
- DONE: done=1 for exactly this cycle; busy still 1; next state IDLE.
- z and underflow are registered on entry to DONE only. Otherwise they hold.
- start outside IDLE is ignored, including in the DONE cycle. Inputs are not re-sampled mid-operation.

## Timing
- Reset values: state IDLE, busy=0, done=0, z=0x000, underflow=0.
- rst has priority over all activity.
  - rst mid-operation aborts to IDLE next edge with no done pulse.
  - rst together with start: the request is dropped.
- Latency, counting start edge = edge 0; done is high after the listed edge:
  - Normal result: edge A+N+2.
  - Zero result: edge A+1.
  - Underflow: edge A+e'+2, where e' is the exponent at NORM entry.
- Worst case: A=7, N=7 → 16 cycles.
- Back-to-back: the earliest next start is the cycle after done (IDLE).

## Test plan
- x=0x2C0 (48), y=0x200 (16), start pulse → d=1, A=1, N=0; after 3 cycles done=1, z=0x280 (32), underflow=0. busy high for 4 cycles.
- Swap case x=0x200, y=0x2C0 → z=0xA80 (sign=1), latency 3. Also repeat with x/y sign bits set: same result.
- Equal operands x=y=0x3A5 → z=0x000, underflow=0, done after edge 1 (latency 1).
- Normalization x=0x481, y=0x480 → m=0x01, N=7; done after edge 9, z=0x100.
- Underflow and large shift:
  - x=0x181, y=0x180 → after 3 shifts e=0; done after edge 5, z=0x000, underflow=1.
  - x=0x600, y=0x080 (d=11) → A=1, z=0x600, latency 3.
- Control corner cases:
  - Start held high through a run: exactly one operation, and the next starts only after done.
  - rst in ALIGN cycle 2: busy=0 next cycle, no done, z=0x000.
  - A subsequent start completes normally.

Source files
------------

// File: rtl/float_sub_12bit_seq.sv
// float_sub_12bit_seq
// Multi-cycle 12-bit floating-point magnitude subtractor: z = |x| - |y|.
// The operand format is {sign, exponent[3:0] (unbiased), fraction[6:0]}
// with a hidden leading 1, so value = 1.f * 2^e. The sign bits of x and y
// are ignored. Alignment and normalization shift one bit per cycle.
//
// Ports
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   start_i      operation request, sampled only while idle
//   x_i          minuend (sign bit ignored)
//   y_i          subtrahend (sign bit ignored)
//   busy_o       high whenever an operation is in flight (state != IDLE)
//   done_o       one-cycle completion pulse; z_o/underflow_o valid from here
//   z_o          result {sign, e, f}; holds until the next completion
//   underflow_o  result was flushed to zero by exponent underflow
module float_sub_12bit_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [11:0] x_i,
  input  logic [11:0] y_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [11:0] z_o,
  output logic        underflow_o
);

  typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [3:0]  exp_q, exp_d;
  logic [3:0]  shift_q, shift_d;
  logic [7:0]  xMant_q, xMant_d;
  logic [7:0]  yMant_q, yMant_d;
  logic [11:0] z_q, z_d;
  logic        underflow_q, underflow_d;

  logic        ySwap;
  logic [7:0]  mantDiff;

  // Comparing {e,f} as one unsigned field orders magnitudes directly,
  // because the exponent sits above the fraction.
  assign ySwap    = (y_i[10:0] > x_i[10:0]);
  // After the swap xMant >= yMant, so this never borrows.
  assign mantDiff = xMant_q - yMant_q;

  // Next-state and datapath logic. xMant doubles as the difference
  // register from SUB onward, and exp tracks the result exponent.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    shift_d     = shift_q;
    xMant_d     = xMant_q;
    yMant_d     = yMant_q;
    z_d         = z_q;
    underflow_d = underflow_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (ySwap) begin
            xMant_d = {1'b1, y_i[6:0]};
            yMant_d = {1'b1, x_i[6:0]};
            exp_d   = y_i[10:7];
            shift_d = y_i[10:7] - x_i[10:7];
            sign_d  = 1'b1;
          end else begin
            xMant_d = {1'b1, x_i[6:0]};
            yMant_d = {1'b1, y_i[6:0]};
            exp_d   = x_i[10:7];
            shift_d = x_i[10:7] - y_i[10:7];
            sign_d  = 1'b0;
          end
          state_d = (shift_d != 4'd0) ? ALIGN : SUB;
        end
      end

      ALIGN: begin
        // A shift of 8 or more moves every mantissa bit out, so clear it
        // in a single cycle instead of walking the remaining distance.
        if (shift_q >= 4'd8) begin
          yMant_d = 8'd0;
          shift_d = 4'd0;
          state_d = SUB;
        end else begin
          yMant_d = yMant_q >> 1;
          shift_d = shift_q - 4'd1;
          if (shift_q == 4'd1) begin
            state_d = SUB;
          end
        end
      end

      SUB: begin
        xMant_d = mantDiff;
        if (mantDiff == 8'd0) begin
          z_d         = 12'h000;
          underflow_d = 1'b0;
          sign_d      = 1'b0;
          state_d     = DONE;
        end else begin
          state_d = NORM;
        end
      end

      NORM: begin
        if (xMant_q[7]) begin
          z_d         = {sign_q, exp_q, xMant_q[6:0]};
          underflow_d = 1'b0;
          state_d     = DONE;
        end else if (exp_q == 4'd0) begin
          // Exponent cannot go lower; flush the result to zero.
          z_d         = 12'h000;
          underflow_d = 1'b1;
          state_d     = DONE;
        end else begin
          xMant_d = xMant_q << 1;
          exp_d   = exp_q - 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset wins over any in-flight operation or request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= 4'd0;
      shift_q     <= 4'd0;
      xMant_q     <= 8'd0;
      yMant_q     <= 8'd0;
      z_q         <= 12'h000;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      shift_q     <= shift_d;
      xMant_q     <= xMant_d;
      yMant_q     <= yMant_d;
      z_q         <= z_d;
      underflow_q <= underflow_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign z_o         = z_q;
  assign underflow_o = underflow_q;

endmodule
